bf_stream_sched: RTL and testbench

Frame scheduler for the beamforming/IFFT playback path. It issues the common `start_pulse` to NUM_CH RAM-to-AXI playback channels (data and coefficient streams) at a fixed frame period, once every channel has finished preloading. It enforces the channel's post-stream guard time, counts frames, and flags any period overrun. It sits in the `clk` domain between the run-control registers and the playback channels.

---
 rtl/bf_stream_sched.sv | 158 +++++++++++++++
 tb/tb_bf_stream_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : bf_stream_sched
// Brief    : Frame-period start scheduler for the beamforming/IFFT playback
//            channels, with post-stream guard, frame count and overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module bf_stream_sched #(
    parameter int NUM_CH       = 2,
    parameter int CNT_WIDTH    = 24,
    parameter int FRM_WIDTH    = 16,
    parameter int GUARD_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [FRM_WIDTH-1:0] cfg_num_frames,
    input  logic [NUM_CH-1:0]    ram_rdy,
    input  logic [NUM_CH-1:0]    bf_stream,
    output logic [NUM_CH-1:0]    start_pulse,
    output logic                 busy,
    output logic [FRM_WIDTH-1:0] frame_cnt,
    output logic                 overrun,
    output logic                 done
);

    localparam int                   c_QW      = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_QW-1:0]      c_GUARD   = c_QW'(GUARD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_MIN_PER = CNT_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_START    = 3'd2,
        S_RUN      = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [FRM_WIDTH-1:0] frames_q, frames_d;
    logic [FRM_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [c_QW-1:0]      quiet_cnt_q, quiet_cnt_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 done_q, done_d;

    logic                 w_quiet;
    logic                 w_frames_reached;

    assign w_quiet          = (quiet_cnt_q == c_GUARD);
    assign w_frames_reached = (frames_q != '0) && (frame_cnt_q == frames_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            period_q    <= '0;
            cnt_q       <= '0;
            frames_q    <= '0;
            frame_cnt_q <= '0;
            quiet_cnt_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            frames_q    <= frames_d;
            frame_cnt_q <= frame_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    // Our own start pulse counts as activity so the guard restarts on every frame.
    always_comb begin
        quiet_cnt_d = quiet_cnt_q;
        if (start_q || (|bf_stream)) begin
            quiet_cnt_d = '0;
        end else if (!w_quiet) begin
            quiet_cnt_d = quiet_cnt_q + c_QW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        frames_d    = frames_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    period_d    = (cfg_period < c_MIN_PER) ? c_MIN_PER : cfg_period;
                    frames_d    = cfg_num_frames;
                    frame_cnt_d = '0;
                    overrun_d   = 1'b0;
                    state_d     = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if ((&ram_rdy) && w_quiet) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Two cycles of the period are spent in START and the final zero cycle.
                cnt_d       = period_q - c_MIN_PER;
                frame_cnt_d = frame_cnt_q + FRM_WIDTH'(1);
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else if (!enable || w_frames_reached) begin
                    state_d = S_DRAIN;
                end else if (w_quiet) begin
                    state_d = S_START;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_quiet) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    assign start_pulse = {NUM_CH{start_q}};
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bf_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_stream_sched
// Brief    : Self-checking bench for bf_stream_sched: timestamp-based reference
//            model compared every cycle, plus hand-computed event timings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_stream_sched;

    localparam int NUM_CH       = 2;
    localparam int CNT_WIDTH    = 24;
    localparam int FRM_WIDTH    = 16;
    localparam int GUARD_CYCLES = 20;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARM   = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [FRM_WIDTH-1:0] cfg_num_frames;
    logic [NUM_CH-1:0]    ram_rdy;
    logic [NUM_CH-1:0]    bf_stream;
    logic [NUM_CH-1:0]    start_pulse;
    logic                 busy;
    logic [FRM_WIDTH-1:0] frame_cnt;
    logic                 overrun;
    logic                 done;

    always #5 clk = ~clk;

    bf_stream_sched #(
        .NUM_CH       (NUM_CH),
        .CNT_WIDTH    (CNT_WIDTH),
        .FRM_WIDTH    (FRM_WIDTH),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .cfg_period     (cfg_period),
        .cfg_num_frames (cfg_num_frames),
        .ram_rdy        (ram_rdy),
        .bf_stream      (bf_stream),
        .start_pulse    (start_pulse),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .overrun        (overrun),
        .done           (done)
    );

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int stream_len = 0;
    int start_q[$];
    int done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: tracks the time of last activity and the cycle at which
    // the current period expires, and derives the expected outputs for the
    // following cycle.
    int                   m_phase;
    int                   m_period;
    int                   m_due;
    int                   m_last_act;
    logic [FRM_WIDTH-1:0] m_frames;
    logic [FRM_WIDTH-1:0] e_cnt;
    logic                 e_start;
    logic                 e_busy;
    logic                 e_ovr;
    logic                 e_done;

    initial begin
        int  t;
        bit  q;
        bit  n_start;
        bit  n_done;
        m_phase    = PH_IDLE;
        m_period   = 2;
        m_due      = 0;
        m_last_act = 0;
        m_frames   = '0;
        e_cnt      = '0;
        e_start    = 1'b0;
        e_busy     = 1'b0;
        e_ovr      = 1'b0;
        e_done     = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase    = PH_IDLE;
                m_last_act = cyc;
                e_cnt      = '0;
                e_start    = 1'b0;
                e_busy     = 1'b0;
                e_ovr      = 1'b0;
                e_done     = 1'b0;
            end else begin
                t = cyc;
                q = (t - m_last_act) > GUARD_CYCLES;
                if (e_start || (bf_stream != '0)) m_last_act = t;
                if (e_start) e_cnt = e_cnt + 1'b1;
                n_start = 1'b0;
                n_done  = 1'b0;
                case (m_phase)
                    PH_IDLE: if (enable) begin
                        m_period = (cfg_period < 2) ? 2 : int'(cfg_period);
                        m_frames = cfg_num_frames;
                        e_cnt    = '0;
                        e_ovr    = 1'b0;
                        m_phase  = PH_ARM;
                    end
                    PH_ARM: begin
                        if (!enable) m_phase = PH_IDLE;
                        else if ((&ram_rdy) && q) begin
                            n_start = 1'b1;
                            m_due   = t + m_period;
                            m_phase = PH_RUN;
                        end
                    end
                    PH_RUN: if (t >= m_due) begin
                        if (!enable || (m_frames != 0 && e_cnt == m_frames)) m_phase = PH_DRAIN;
                        else if (q) begin
                            n_start = 1'b1;
                            m_due   = t + m_period;
                        end else e_ovr = 1'b1;
                    end
                    default: if (q) begin
                        n_done  = 1'b1;
                        m_phase = PH_IDLE;
                    end
                endcase
                e_start = n_start;
                e_done  = n_done;
                e_busy  = (m_phase != PH_IDLE);
            end
        end
    end

    // Channel model: streams for stream_len cycles starting with each start pulse.
    initial begin
        int rem;
        rem = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                rem       = 0;
                bf_stream = '0;
            end else begin
                if (e_start) rem = stream_len;
                if (rem > 0) begin
                    bf_stream = '1;
                    rem--;
                end else bf_stream = '0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (start_pulse !== {NUM_CH{e_start}} || busy !== e_busy || frame_cnt !== e_cnt ||
                    overrun !== e_ovr || done !== e_done) begin
                    errors++;
                    $display("FAIL cycle_compare @%0d: dut sp=%b busy=%b fc=%0d ovr=%b done=%b, model sp=%b busy=%b fc=%0d ovr=%b done=%b",
                             cyc, start_pulse, busy, frame_cnt, overrun, done,
                             {NUM_CH{e_start}}, e_busy, e_cnt, e_ovr, e_done);
                end
                if (start_pulse != '0) start_q.push_back(cyc);
                if (done) done_q.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    function automatic int sq(input int i);
        return (i < start_q.size()) ? start_q[i] : -100000;
    endfunction

    function automatic int dq(input int i);
        return (i < done_q.size()) ? done_q[i] : -100000;
    endfunction

    task automatic clear_q();
        start_q.delete();
        done_q.delete();
    endtask

    task automatic wait_starts(input int k, input int limit);
        int i;
        i = 0;
        while (start_q.size() < k && i < limit) begin
            step(1);
            i++;
        end
        chk("start_wait", (start_q.size() >= k) ? k : start_q.size(), k);
    endtask

    task automatic wait_done(input int k, input int limit);
        int i;
        i = 0;
        while (done_q.size() < k && i < limit) begin
            step(1);
            i++;
        end
        chk("done_wait", (done_q.size() >= k) ? k : done_q.size(), k);
    endtask

    initial begin
        int c;
        int e;
        int d;
        rst            = 1'b1;
        enable         = 1'b0;
        cfg_period     = 4;
        cfg_num_frames = 1;
        ram_rdy        = '0;
        step(3);
        chk("reset_outputs", {start_pulse, busy, frame_cnt, overrun, done}, 0);
        rst = 1'b0;
        step(25);

        // Partial ready holds off the start; full ready starts the next cycle.
        clear_q();
        ram_rdy = 2'b01;
        enable  = 1'b1;
        step(10);
        chk("partial_rdy_no_start", start_q.size(), 0);
        chk("busy_while_waiting", busy, 1);
        ram_rdy = 2'b11;
        c = cyc;
        wait_starts(1, 10);
        chk("rdy_to_start", sq(0) - c, 1);
        enable = 1'b0;
        step(1);
        chk("start_one_cycle", start_pulse, 0);
        chk("frame_cnt_after_start", frame_cnt, 1);
        wait_done(1, 100);
        chk("done_after_start_guard", dq(0) - sq(0), 22);

        // Three bounded frames, period 1000, stream 800.
        clear_q();
        cfg_period     = 1000;
        cfg_num_frames = 3;
        stream_len     = 800;
        enable         = 1'b1;
        e = cyc;
        wait_starts(3, 2600);
        enable = 1'b0;
        wait_done(1, 1500);
        chk("enable_to_start", sq(0) - e, 2);
        chk("spacing_1000_a", sq(1) - sq(0), 1000);
        chk("spacing_1000_b", sq(2) - sq(1), 1000);
        chk("frames_3", frame_cnt, 3);
        chk("no_overrun", overrun, 0);
        chk("done_after_period", dq(0) - sq(2), 1001);
        chk("busy_low_at_done", busy, 0);

        // Stream longer than the period: overrun, start one cycle after quiet.
        clear_q();
        cfg_period     = 500;
        cfg_num_frames = 3;
        stream_len     = 600;
        enable         = 1'b1;
        wait_starts(1, 10);
        chk("overrun_clear_run_start", overrun, 0);
        wait_starts(2, 800);
        chk("overrun_set", overrun, 1);
        chk("overrun_spacing_a", sq(1) - sq(0), 621);
        wait_starts(3, 800);
        enable = 1'b0;
        chk("overrun_spacing_b", sq(2) - sq(1), 621);
        wait_done(1, 800);
        chk("done_after_stream_guard", dq(0) - sq(2), 621);
        chk("overrun_sticky", overrun, 1);

        // Continuous mode, enable dropped mid-period.
        clear_q();
        cfg_period     = 300;
        cfg_num_frames = 0;
        stream_len     = 100;
        enable         = 1'b1;
        wait_starts(4, 1400);
        chk("cont_spacing_a", sq(1) - sq(0), 300);
        chk("cont_spacing_c", sq(3) - sq(2), 300);
        step(1);
        chk("cont_frame_cnt", frame_cnt, 4);
        step(148);
        enable = 1'b0;
        wait_done(1, 400);
        chk("cont_no_more_starts", start_q.size(), 4);
        chk("cont_done", dq(0) - sq(3), 301);

        // Config changes mid-run are ignored; enable held restarts with new config.
        clear_q();
        cfg_period     = 1000;
        cfg_num_frames = 2;
        stream_len     = 0;
        enable         = 1'b1;
        wait_starts(1, 10);
        cfg_period     = 200;
        cfg_num_frames = 5;
        wait_done(1, 2200);
        d = dq(0);
        chk("shadow_spacing", sq(1) - sq(0), 1000);
        chk("shadow_frames", start_q.size(), 2);
        chk("shadow_frame_cnt", frame_cnt, 2);
        wait_starts(4, 600);
        enable = 1'b0;
        chk("restart_after_done", sq(2) - d, 2);
        chk("new_period_spacing", sq(3) - sq(2), 200);
        wait_done(2, 600);

        // Period 0 clamps to 2; the guard after each start then forces overrun.
        clear_q();
        cfg_period     = 0;
        cfg_num_frames = 2;
        enable         = 1'b1;
        wait_starts(2, 100);
        enable = 1'b0;
        chk("period0_spacing", sq(1) - sq(0), 22);
        chk("period0_overrun", overrun, 1);
        wait_done(1, 100);
        chk("period0_done", dq(0) - sq(1), 22);

        // Asynchronous reset while start_pulse is high.
        clear_q();
        cfg_period     = 300;
        cfg_num_frames = 0;
        stream_len     = 50;
        enable         = 1'b1;
        wait_starts(1, 10);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", {start_pulse, busy, frame_cnt, overrun, done}, 0);
        enable = 1'b0;
        step(2);
        rst = 1'b0;
        step(30);
        chk("no_restart_without_enable", start_q.size(), 1);
        chk("idle_after_reset", busy, 0);
        enable = 1'b1;
        e = cyc;
        wait_starts(2, 10);
        chk("restart_enable_to_start", sq(1) - e, 2);
        enable = 1'b0;
        wait_done(1, 400);
        chk("restart_done", dq(0) - sq(1), 301);

        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
